rmii_mac_tx: RTL and testbench
==============================

# rmii_mac_tx

RMII MAC transmitter for Fast Ethernet, the transmit-side counterpart of the RMII MAC receiver. It accepts a frame payload as a 2-bit AXI stream and drives the PHY's TXD/TXEN at one dibit per 50 MHz clock. It prepends the preamble and SFD and enforces the inter-frame gap. When the FCS feature is compiled in, it also pads short frames and appends the CRC-32 FCS.

## Interface
- IFG_DIBITS, 48: idle cycles with txen low between frames (96 bit times).
- clock  in  1  50 MHz reference clock, shared with the PHY.
- arst_n  in  1  asynchronous reset, active low.
- axi_tvalid  in  1  upstream payload dibit valid.
- axi_tlast  in  1  last payload dibit of the frame.
- axi_tdata  in  2  payload dibit; bit 0 is the earlier bit on the wire.
- axi_tready  out  1  payload dibit accepted when high together with axi_tvalid.
- txd  out  2  RMII transmit data to the PHY.
- txen  out  1  RMII transmit enable.
- tx_underrun  out  1  one-cycle pulse when a frame is aborted by an underrun.

## Operation
- States: IDLE, PREAMBLE, DATA, PAD, FCS, DRAIN, IFG.
- **IDLE**
  - txen=0, txd=00, axi_tready=0.
  - axi_tvalid=1 → PREAMBLE. The beat is not consumed.
- **PREAMBLE**
  - 32 cycles: 31 dibits of 01, then one dibit of 11 (0x55×7 followed by 0xD5, sent LSB first).
  - axi_tready=1 during the cycle that shows the 11 dibit, so the first payload dibit follows with no gap.
  - axi_tvalid=0 in that cycle is an underrun.
- **DATA**
  - axi_tready=1 on every cycle.
  - A beat accepted in cycle N appears on txd in cycle N+1.
  - Underrun: axi_tvalid=0 in any DATA cycle (or in the SFD cycle) while the frame is open:
    - txen drops in the next cycle;
    - tx_underrun pulses;
    - state goes to DRAIN.
  - Beat accepted with axi_tlast=1 → PAD, FCS or IFG (see Configuration).
- **DRAIN**
  - txen=0, axi_tready=1.
  - Accepted beats are discarded.
  - A beat accepted with axi_tlast=1 → IFG.
- **IFG**
  - txen=0, txd=00, axi_tready=0 for IFG_DIBITS cycles, counted from the first cycle with txen low → IDLE.
- Frame dibit counter: 8 bits, saturating at 240 (60 bytes). It counts payload and pad dibits.
- Payload length is not checked for whole bytes. Dibits are sent exactly as received.
- axi_tlast on the first beat is legal.

## Timing
- Reset values: txen=0, txd=00, axi_tready=0, tx_underrun=0, state=IDLE, all counters 0.
- Reset assertion mid-frame takes effect immediately (asynchronous). txen falls without completing the frame.
- txd, txen and tx_underrun are registered. axi_tready is decoded from the registered state and counter only, with no combinational path from axi_tvalid.
- Latency: axi_tvalid rises in IDLE in cycle 0 → first preamble dibit on txd in cycle 1; first payload dibit on txd in cycle 33.
- txen high time = 32 + payload (+ pad + 16 FCS) cycles, with no holes.
- Back-to-back frames: axi_tvalid held high → exactly IFG_DIBITS + 1 cycles between the txen falling edge and the next rising edge (IFG plus one IDLE cycle).

## Configuration
- RMII_MAC_TX_FCS_EN defined:
  - If tlast arrives with counter < 240 → PAD: send 00 dibits until the counter reaches 240.
  - Then FCS: 16 dibits of the CRC-32, LSB first.
  - CRC parameters: reflected polynomial 0xEDB88320, initial value all ones, 2 bits per cycle over payload and pad, transmitted value is the complement.
  - txen falls after the last FCS dibit.
- RMII_MAC_TX_FCS_EN undefined:
  - No PAD/FCS states; tlast → IFG.
  - Upstream supplies pad and FCS.
  - The frame dibit counter and CRC logic are absent.

## Structure
- Package rmii_mac_pkg holds:
  - the state enum;
  - PREAMBLE_DIBITS=32, SFD_DIBIT=2'b11, PREAMBLE_DIBIT=2'b01;
  - MIN_FRAME_DIBITS=240, FCS_DIBITS=16;
  - CRC32_POLY_REFL=32'hEDB88320.
- Sub-module rmii_crc32_dibit implements the CRC-32 stepped 2 bits per cycle, with clear/enable inputs. It is instantiated only under RMII_MAC_TX_FCS_EN.

## Test plan
- **64-byte frame, FCS off, no gaps:** 256 dibits in → txen high 288 cycles; txd shows 31×01, then 11, then the payload in order; txen low ≥48 cycles afterwards.
- **14-byte frame, FCS on:** txen high 288 cycles; 184 pad dibits of 00; 16 FCS dibits match a software CRC-32. Second case: the 9-byte payload "123456789" with no padding is not legal, so run it through the bench model of rmii_crc32_dibit alone and expect result 0xCBF43926.
- **Underrun:** axi_tvalid drops at payload dibit 100 → txen low the next cycle, one tx_underrun pulse, remaining beats accepted with txen low until tlast, then a 48-cycle IFG.
- **Back-to-back:** two 64-byte frames with axi_tvalid continuously high → exactly 49 cycles of txen low between the frames.
- **Reset mid-frame:** arst_n asserted during payload → txen=0, txd=00, axi_tready=0 immediately; after release, a new frame starts cleanly with a full preamble.
- **Single-beat frame:** tlast on the first beat with FCS off → txen high for exactly 33 cycles.

Source files
------------

// File: rtl/rmii_mac_pkg.sv
// rmii_mac_pkg: shared types, framing constants and the dibit CRC-32 step
// used by the RMII MAC transmitter.
package rmii_mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_PAD      = 3'd3,
        ST_FCS      = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_IFG      = 3'd6
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_DIBITS  = 8'd32;
    localparam logic [1:0]  SFD_DIBIT        = 2'b11;
    localparam logic [1:0]  PREAMBLE_DIBIT   = 2'b01;
    localparam logic [7:0]  MIN_FRAME_DIBITS = 8'd240;
    localparam logic [7:0]  FCS_DIBITS       = 8'd16;
    localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT       = 32'hFFFF_FFFF;

    // Advance a reflected CRC-32 by one dibit; din[0] is the earlier bit.
    function automatic logic [31:0] crc32_step2(input logic [31:0] crc_in,
                                                input logic [1:0]  din);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ din[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_crc32_dibit.sv
// rmii_crc32_dibit: running CRC-32 (reflected 0xEDB88320, preset all ones)
// advanced by one dibit per enabled cycle. clr restarts it for a new frame.
module rmii_crc32_dibit
    import rmii_mac_pkg::*;
(
    input  logic        clock,
    input  logic        arst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  din,
    output logic [31:0] crc
);

    logic [31:0] crc_r;

    // CRC register: preset on reset or clear, stepped when a dibit is sent.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            crc_r <= CRC32_INIT;
        end else if (clr) begin
            crc_r <= CRC32_INIT;
        end else if (en) begin
            crc_r <= crc32_step2(crc_r, din);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/rmii_mac_tx.sv
// rmii_mac_tx: RMII MAC transmitter. Takes a 2-bit AXI payload stream, sends
// preamble + SFD, the payload, and then enforces the inter-frame gap.
// Build option RMII_MAC_TX_FCS_EN: pad short frames to 60 bytes with zero
// dibits and append the CRC-32 FCS. Without it, upstream supplies both.
module rmii_mac_tx
    import rmii_mac_pkg::*;
#(
    parameter int IFG_DIBITS = 48
) (
    input  logic       clock,
    input  logic       arst_n,
    input  logic       axi_tvalid,
    input  logic       axi_tlast,
    input  logic [1:0] axi_tdata,
    output logic       axi_tready,
    output logic [1:0] txd,
    output logic       txen,
    output logic       tx_underrun
);

    localparam logic [7:0] IFG_LAST  = 8'(IFG_DIBITS - 1);
    localparam logic [7:0] SFD_INDEX = PREAMBLE_DIBITS - 8'd1;

    tx_state_e  state_r;
    logic [7:0] cnt_r;
    logic [1:0] txd_r;
    logic       txen_r;
    logic       tx_underrun_r;
    logic       ready_s;
    tx_state_e  end_state_s;

`ifdef RMII_MAC_TX_FCS_EN
    localparam logic [7:0] FCS_LAST = FCS_DIBITS - 8'd1;

    logic [7:0]  frame_cnt_r;
    logic [7:0]  frame_cnt_inc_s;
    logic [31:0] crc_s;
    logic [31:0] fcs_s;
    logic [1:0]  fcs_dibit_s;
    logic        crc_clr_s;
    logic        crc_en_s;
    logic [1:0]  crc_din_s;
`endif

    // Ready decodes from state and counter only: SFD cycle, DATA and DRAIN.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_PREAMBLE:       ready_s = (cnt_r == SFD_INDEX);
            ST_DATA, ST_DRAIN: ready_s = 1'b1;
            default:           ready_s = 1'b0;
        endcase
    end

`ifdef RMII_MAC_TX_FCS_EN
    // Frame length, CRC feed and the FCS dibit selected by the FCS index.
    always_comb begin
        if (frame_cnt_r == MIN_FRAME_DIBITS) begin
            frame_cnt_inc_s = frame_cnt_r;
        end else begin
            frame_cnt_inc_s = frame_cnt_r + 8'd1;
        end
        crc_clr_s = (state_r == ST_IDLE);
        if (state_r == ST_PAD) begin
            crc_en_s  = 1'b1;
            crc_din_s = 2'b00;
        end else begin
            crc_en_s  = ready_s && axi_tvalid && (state_r != ST_DRAIN);
            crc_din_s = axi_tdata;
        end
        fcs_s       = ~crc_s;
        fcs_dibit_s = fcs_s[{cnt_r[3:0], 1'b0} +: 2];
    end

    // Payload plus pad dibit count, saturating at the minimum frame size.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            frame_cnt_r <= 8'd0;
        end else if (state_r == ST_IDLE) begin
            frame_cnt_r <= 8'd0;
        end else if (crc_en_s) begin
            frame_cnt_r <= frame_cnt_inc_s;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    rmii_crc32_dibit u_crc (
        .clock  (clock),
        .arst_n (arst_n),
        .clr    (crc_clr_s),
        .en     (crc_en_s),
        .din    (crc_din_s),
        .crc    (crc_s)
    );
`endif

    // State entered after the dibit flagged with tlast has been accepted.
    always_comb begin
`ifdef RMII_MAC_TX_FCS_EN
        if (frame_cnt_inc_s < MIN_FRAME_DIBITS) begin
            end_state_s = ST_PAD;
        end else begin
            end_state_s = ST_FCS;
        end
`else
        end_state_s = ST_IFG;
`endif
    end

    // Transmit FSM; txd/txen hold the dibit to show in the following cycle.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            txd_r         <= 2'b00;
            txen_r        <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            tx_underrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 8'd0;
                    if (axi_tvalid) begin
                        state_r <= ST_PREAMBLE;
                        txd_r   <= PREAMBLE_DIBIT;
                        txen_r  <= 1'b1;
                    end else begin
                        txd_r  <= 2'b00;
                        txen_r <= 1'b0;
                    end
                end
                ST_PREAMBLE, ST_DATA: begin
                    if (!ready_s) begin
                        // Still inside the preamble; the last one is the SFD.
                        cnt_r  <= cnt_r + 8'd1;
                        txd_r  <= (cnt_r == SFD_INDEX - 8'd1) ? SFD_DIBIT : PREAMBLE_DIBIT;
                        txen_r <= 1'b1;
                    end else if (axi_tvalid) begin
                        cnt_r   <= 8'd0;
                        txd_r   <= axi_tdata;
                        txen_r  <= 1'b1;
                        state_r <= axi_tlast ? end_state_s : ST_DATA;
                    end else begin
                        // Upstream starved an open frame: abort it on the wire.
                        cnt_r         <= 8'd0;
                        txd_r         <= 2'b00;
                        txen_r        <= 1'b0;
                        tx_underrun_r <= 1'b1;
                        state_r       <= ST_DRAIN;
                    end
                end
`ifdef RMII_MAC_TX_FCS_EN
                ST_PAD: begin
                    txd_r  <= 2'b00;
                    txen_r <= 1'b1;
                    if (frame_cnt_inc_s == MIN_FRAME_DIBITS) begin
                        state_r <= ST_FCS;
                        cnt_r   <= 8'd0;
                    end
                end
                ST_FCS: begin
                    txd_r  <= fcs_dibit_s;
                    txen_r <= 1'b1;
                    if (cnt_r == FCS_LAST) begin
                        state_r <= ST_IFG;
                        cnt_r   <= 8'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
`endif
                ST_DRAIN: begin
                    txd_r  <= 2'b00;
                    txen_r <= 1'b0;
                    if (axi_tvalid && axi_tlast) begin
                        state_r <= ST_IFG;
                        cnt_r   <= 8'd0;
                    end
                end
                ST_IFG: begin
                    txd_r  <= 2'b00;
                    txen_r <= 1'b0;
                    // Gap is counted only once txen is actually low on the wire.
                    if (!txen_r) begin
                        if (cnt_r == IFG_LAST) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= 8'd0;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'd0;
                    txd_r   <= 2'b00;
                    txen_r  <= 1'b0;
                end
            endcase
        end
    end

    assign axi_tready  = ready_s;
    assign txd         = txd_r;
    assign txen        = txen_r;
    assign tx_underrun = tx_underrun_r;

endmodule

// File: tb/tb_rmii_mac_tx.sv
// tb_rmii_mac_tx: randomized frames against a per-cycle expectation stream
// built from the framing rules (preamble, payload, pad/FCS, gap, underrun).
module tb_rmii_mac_tx;

    logic       clock;
    logic       arst_n;
    logic       axi_tvalid;
    logic       axi_tlast;
    logic [1:0] axi_tdata;
    logic       axi_tready;
    logic [1:0] txd;
    logic       txen;
    logic       tx_underrun;

    rmii_mac_tx #(.IFG_DIBITS(48)) dut (
        .clock       (clock),
        .arst_n      (arst_n),
        .axi_tvalid  (axi_tvalid),
        .axi_tlast   (axi_tlast),
        .axi_tdata   (axi_tdata),
        .axi_tready  (axi_tready),
        .txd         (txd),
        .txen        (txen),
        .tx_underrun (tx_underrun)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

`ifdef RMII_MAC_TX_FCS_EN
    localparam int N_BIG   = 56;
    localparam int HI_BIG  = 288;
    localparam int HI_ONE  = 288;
    localparam int HI_POST = 288;
`else
    localparam int N_BIG   = 256;
    localparam int HI_BIG  = 288;
    localparam int HI_ONE  = 33;
    localparam int HI_POST = 52;
`endif

    typedef struct packed {
        logic       rst_n;
        logic       vld;
        logic       last;
        logic [1:0] data;
        logic       e_txen;
        logic [1:0] e_txd;
        logic       e_rdy;
        logic       e_und;
    } rec_t;

    rec_t       rec_q[$];
    rec_t       exp_q[$];
    logic [1:0] beat [0:511];
    int         hi_q[$];
    int         lo_q[$];
    int         und_cnt = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        if (c[0] ^ b) return (c >> 1) ^ 32'hEDB88320;
        return c >> 1;
    endfunction

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        return crc_bit(crc_bit(c, d[0]), d[1]);
    endfunction

    function automatic int last_hi();
        if (hi_q.size() == 0) return -1;
        return hi_q[hi_q.size() - 1];
    endfunction

    function automatic int last_lo();
        if (lo_q.size() == 0) return -1;
        return lo_q[lo_q.size() - 1];
    endfunction

    task automatic gen_beats(input int n);
        for (int i = 0; i < n; i++) beat[i] = 2'($urandom_range(0, 3));
    endtask

    task automatic add_idle(input int n, input logic rst_n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r = '0;
            r.rst_n = rst_n;
            rec_q.push_back(r);
        end
    endtask

    // Cycle 0 is the IDLE cycle that sees tvalid; u >= 0 starves beat u;
    // cut >= 0 stops the frame after that many cycles.
    task automatic add_frame(input int n, input int u, input int cut);
        logic [1:0] wl[$];
        rec_t       r;
        int         k;
        int         len;
        int         tot;
`ifdef RMII_MAC_TX_FCS_EN
        logic [31:0] crc;
`endif
        wl = {};
        for (int i = 0; i < n; i++) wl.push_back(beat[i]);
`ifdef RMII_MAC_TX_FCS_EN
        if (u < 0) begin
            while (wl.size() < 240) wl.push_back(2'b00);
            crc = 32'hFFFF_FFFF;
            foreach (wl[i]) crc = crc_dibit(crc, wl[i]);
            crc = ~crc;
            for (int i = 0; i < 16; i++) wl.push_back(crc[2*i +: 2]);
        end
`endif
        len = wl.size();
        tot = (u < 0) ? 81 + len : 81 + n;
        for (int c = 0; c < tot; c++) begin
            if (cut >= 0 && c >= cut) break;
            r = '0;
            r.rst_n = 1'b1;
            if (u < 0) begin
                if (c <= 31 + n) begin
                    k = (c < 32) ? 0 : c - 32;
                    r.vld = 1'b1; r.data = beat[k]; r.last = (k == n - 1);
                end
                r.e_txen = (c >= 1 && c <= 32 + len);
                r.e_rdy  = (c >= 32 && c <= 31 + n);
            end else begin
                if (c < 32 + u) begin
                    k = (c < 32) ? 0 : c - 32;
                    r.vld = 1'b1; r.data = beat[k]; r.last = (k == n - 1);
                end else if (c >= 33 + u && c <= 32 + n) begin
                    k = c - 33;
                    r.vld = 1'b1; r.data = beat[k]; r.last = (k == n - 1);
                end
                r.e_txen = (c >= 1 && c <= 32 + u);
                r.e_rdy  = (c >= 32 && c <= 32 + n);
                r.e_und  = (c == 33 + u);
            end
            if (r.e_txen) begin
                if (c <= 31) r.e_txd = 2'b01;
                else if (c == 32) r.e_txd = 2'b11;
                else r.e_txd = wl[c - 33];
            end
            rec_q.push_back(r);
        end
    endtask

    task automatic play();
        rec_t r;
        while (rec_q.size() > 0) begin
            r = rec_q.pop_front();
            @(posedge clock);
            #1;
            arst_n     = r.rst_n;
            axi_tvalid = r.vld;
            axi_tlast  = r.last;
            axi_tdata  = r.data;
            exp_q.push_back(r);
        end
        @(negedge clock);
        #1;
    endtask

    // Compare process: checks every expected cycle and tracks txen run lengths.
    initial begin
        rec_t r;
        logic prev_txen;
        int   run;
        prev_txen = 1'b0;
        run = 0;
        forever begin
            @(negedge clock);
            if (txen === prev_txen) begin
                run++;
            end else begin
                if (prev_txen) hi_q.push_back(run);
                else lo_q.push_back(run);
                run = 1;
                prev_txen = txen;
            end
            if (tx_underrun === 1'b1) und_cnt++;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("txen",        32'(txen),        32'(r.e_txen));
                chk("txd",         32'(txd),         32'(r.e_txd));
                chk("axi_tready",  32'(axi_tready),  32'(r.e_rdy));
                chk("tx_underrun", 32'(tx_underrun), 32'(r.e_und));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        string       s;
        logic [31:0] crc;
        logic [7:0]  bt;
        int          n;
        int          u;
        int          und0;

        arst_n = 1'b0; axi_tvalid = 1'b0; axi_tlast = 1'b0; axi_tdata = 2'b00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_txen",  32'(txen),        32'd0);
        chk("reset_txd",   32'(txd),         32'd0);
        chk("reset_ready", 32'(axi_tready),  32'd0);
        chk("reset_und",   32'(tx_underrun), 32'd0);

        // Model pin: check value of the dibit CRC over "123456789".
        s = "123456789";
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) begin
            bt = s[i];
            for (int j = 0; j < 4; j++) crc = crc_dibit(crc, bt[2*j +: 2]);
        end
        chk("crc_check_value", ~crc, 32'hCBF43926);

        add_idle(4, 1'b1);
        play();

        // Two frames back to back with tvalid held high.
        gen_beats(N_BIG); add_frame(N_BIG, -1, -1); play();
        chk("frame_a_txen_high", 32'(last_hi()), 32'(HI_BIG));
        gen_beats(N_BIG); add_frame(N_BIG, -1, -1); play();
        chk("b2b_txen_low", 32'(last_lo()), 32'd49);
        chk("frame_b_txen_high", 32'(last_hi()), 32'(HI_BIG));

        // Single-beat frame after a short idle gap.
        add_idle(3, 1'b1);
        gen_beats(1); add_frame(1, -1, -1); play();
        chk("single_txen_high", 32'(last_hi()), 32'(HI_ONE));

        // Underrun at payload dibit 100.
        und0 = und_cnt;
        gen_beats(200); add_frame(200, 100, -1); play();
        chk("underrun_pulses", 32'(und_cnt - und0), 32'd1);
        chk("underrun_txen_high", 32'(last_hi()), 32'd132);

        // Randomized frames, some starved, with random idle gaps.
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 300);
            u = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            add_idle($urandom_range(0, 3), 1'b1);
            gen_beats(n); add_frame(n, u, -1); play();
        end

        // Reset in the middle of a payload, then a clean frame.
        gen_beats(100); add_frame(100, -1, 60);
        add_idle(3, 1'b0);
        add_idle(2, 1'b1);
        play();
        gen_beats(20); add_frame(20, -1, -1); play();
        chk("post_reset_txen_high", 32'(last_hi()), 32'(HI_POST));

        add_idle(5, 1'b1);
        play();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
